// File: rtl/commit_arb_pkg.sv
// Shared definitions for the commit arbiter: the "no write" register number,
// default widths, and the perf-counter width shared with other counters.
package commit_arb_pkg;

   localparam int RN_NONE    = 0;
   localparam int DEF_DATA_W = 64;
   localparam int DEF_RN_W   = 6;
   localparam int CNT_W      = 32;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: one-hot mask of the first requester at or after ptr,
// wrapping modulo N.
module rr_pick #(
   parameter int N  = 5,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt
);

   always_comb begin
      int  idx;
      logic found;
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int off = 0; off < N; off++) begin
         idx = int'(ptr) + off;
         if (idx >= N) idx = idx - N;
         if (req[idx] && !found) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/commit_arb.sv
// Round-robin commit arbiter: N_UNITS result channels onto N_WPORTS registered
// regfile write ports. Define COMMIT_ARB_STATS_EN to enable the conflict counter.
module commit_arb
   import commit_arb_pkg::*;
#(
   parameter int N_UNITS  = 5,
   parameter int N_WPORTS = 2,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int RN_W     = DEF_RN_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_UNITS-1:0]           unit_valid,
   input  logic [N_UNITS*RN_W-1:0]      unit_rn,
   input  logic [N_UNITS*DATA_W-1:0]    unit_data,
   output logic [N_UNITS-1:0]           unit_stall,
   output logic [N_WPORTS*RN_W-1:0]     write_rn,
   output logic [N_WPORTS*DATA_W-1:0]   write_data,
   output logic [CNT_W-1:0]             conflict_cnt
);

   localparam int PTR_W = $clog2(N_UNITS);

   logic [PTR_W-1:0]             ptr_q, ptr_d;
   logic [N_UNITS-1:0]           req;
   logic [N_UNITS-1:0]           granted_any;
   logic [N_UNITS-1:0]           req_stage [N_WPORTS];
   logic [N_UNITS-1:0]           gnt_stage [N_WPORTS];
   logic [N_WPORTS*RN_W-1:0]     write_rn_q, write_rn_d;
   logic [N_WPORTS*DATA_W-1:0]   write_data_q, write_data_d;

   // rn 0 is a discard: accepted silently, never arbitrated.
   always_comb begin
      req = '0;
      for (int i = 0; i < N_UNITS; i++) begin
         req[i] = unit_valid[i] && (unit_rn[i*RN_W +: RN_W] != RN_W'(RN_NONE));
      end
   end

   assign req_stage[0] = req;

   // Every stage scans from the same ptr; masking earlier winners makes each
   // stage pick the next requester in scan order.
   for (genvar k = 0; k < N_WPORTS; k++) begin : g_stage
      logic [RN_W-1:0]   rn_g;
      logic [DATA_W-1:0] data_g;

      rr_pick #(.N(N_UNITS), .PW(PTR_W)) u_pick (
         .req (req_stage[k]),
         .ptr (ptr_q),
         .gnt (gnt_stage[k])
      );

      always_comb begin
         rn_g   = '0;
         data_g = '0;
         for (int i = 0; i < N_UNITS; i++) begin
            if (gnt_stage[k][i]) begin
               rn_g   = unit_rn[i*RN_W +: RN_W];
               data_g = unit_data[i*DATA_W +: DATA_W];
            end
         end
      end

      assign write_rn_d[k*RN_W +: RN_W]       = rn_g;
      assign write_data_d[k*DATA_W +: DATA_W] = data_g;

      if (k < N_WPORTS - 1) begin : g_mask
         logic [N_UNITS-1:0] dup;

         // With no grant rn_g is 0, which no requester can match.
         always_comb begin
            dup = '0;
            for (int i = 0; i < N_UNITS; i++) begin
               dup[i] = (unit_rn[i*RN_W +: RN_W] == rn_g);
            end
         end

         assign req_stage[k+1] = req_stage[k] & ~gnt_stage[k] & ~dup;
      end
   end

   // Later stages overwrite ptr_d, so it lands just past the last grant.
   always_comb begin
      granted_any = '0;
      ptr_d       = ptr_q;
      for (int k = 0; k < N_WPORTS; k++) begin
         for (int i = 0; i < N_UNITS; i++) begin
            if (gnt_stage[k][i]) begin
               granted_any[i] = 1'b1;
               ptr_d = (i == N_UNITS - 1) ? '0 : PTR_W'(i + 1);
            end
         end
      end
   end

   assign unit_stall = req & ~granted_any;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q        <= '0;
         write_rn_q   <= '0;
         write_data_q <= '0;
      end else begin
         ptr_q        <= ptr_d;
         write_rn_q   <= write_rn_d;
         write_data_q <= write_data_d;
      end
   end

   assign write_rn   = write_rn_q;
   assign write_data = write_data_q;

`ifdef COMMIT_ARB_STATS_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (|unit_stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign conflict_cnt = cnt_q;
`else
   assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_commit_arb.sv
// Self-checking bench for commit_arb at default parameters (5 units, 2 ports);
// expected conflict_cnt follows COMMIT_ARB_STATS_EN.
module tb_commit_arb;

   localparam int NU = 5;
   localparam int NW = 2;
   localparam int DW = 64;
   localparam int RW = 6;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NU-1:0]     unit_valid = '0;
   logic [NU*RW-1:0]  unit_rn    = '0;
   logic [NU*DW-1:0]  unit_data  = '0;
   logic [NU-1:0]     unit_stall;
   logic [NW*RW-1:0]  write_rn;
   logic [NW*DW-1:0]  write_data;
   logic [31:0]       conflict_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state: what the outputs must show now, and what the
   // next edge must produce.
   int          m_ptr = 0;
   logic [RW-1:0] m_rn   [NW];
   logic [DW-1:0] m_data [NW];
   logic [31:0] m_cnt = '0;
   int          nx_ptr = 0;
   logic [RW-1:0] nx_rn   [NW];
   logic [DW-1:0] nx_data [NW];
   logic [31:0] nx_cnt = '0;

   commit_arb dut (
      .clk          (clk),
      .rst          (rst),
      .unit_valid   (unit_valid),
      .unit_rn      (unit_rn),
      .unit_data    (unit_data),
      .unit_stall   (unit_stall),
      .write_rn     (write_rn),
      .write_data   (write_data),
      .conflict_cnt (conflict_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input int u, input logic v, input logic [RW-1:0] rn, input logic [DW-1:0] d);
      unit_valid[u]         = v;
      unit_rn[u*RW +: RW]   = rn;
      unit_data[u*DW +: DW] = d;
   endtask

   task automatic clearUnits();
      unit_valid = '0;
      unit_rn    = '0;
      unit_data  = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: walk units in scan order from ptr, hand out up to NW ports to
   // requesters whose rn has not been written yet this cycle.
   always @(negedge clk) begin
      logic [NU-1:0] e_stall;
      logic [RW-1:0] taken [$];
      logic [RW-1:0] r;
      int            u, last, ng;
      bit            dup;
      e_stall = '0;
      taken.delete();
      last = -1;
      ng   = 0;
      for (int p = 0; p < NW; p++) begin
         nx_rn[p]   = '0;
         nx_data[p] = '0;
      end
      for (int off = 0; off < NU; off++) begin
         u = (m_ptr + off) % NU;
         r = unit_rn[u*RW +: RW];
         if (unit_valid[u] && r != 0) begin
            dup = 1'b0;
            foreach (taken[j]) if (taken[j] == r) dup = 1'b1;
            if (ng < NW && !dup) begin
               nx_rn[ng]   = r;
               nx_data[ng] = unit_data[u*DW +: DW];
               taken.push_back(r);
               ng++;
               last = u;
            end else begin
               e_stall[u] = 1'b1;
            end
         end
      end
      nx_ptr = (last >= 0) ? (last + 1) % NU : m_ptr;
`ifdef COMMIT_ARB_STATS_EN
      nx_cnt = (e_stall != 0 && m_cnt != 32'hFFFF_FFFF) ? m_cnt + 1 : m_cnt;
`else
      nx_cnt = '0;
`endif
      checkOutput("unit_stall", 128'(unit_stall), 128'(e_stall));
      for (int p = 0; p < NW; p++) begin
         checkOutput($sformatf("port%0d_rn", p), 128'(write_rn[p*RW +: RW]), 128'(m_rn[p]));
         checkOutput($sformatf("port%0d_data", p), 128'(write_data[p*DW +: DW]), 128'(m_data[p]));
      end
      checkOutput("conflict_cnt", 128'(conflict_cnt), 128'(m_cnt));
   end

   always @(posedge clk) begin
      if (rst) begin
         m_ptr = 0;
         m_cnt = '0;
         for (int p = 0; p < NW; p++) begin
            m_rn[p]   = '0;
            m_data[p] = '0;
         end
      end else begin
         m_ptr = nx_ptr;
         m_cnt = nx_cnt;
         for (int p = 0; p < NW; p++) begin
            m_rn[p]   = nx_rn[p];
            m_data[p] = nx_data[p];
         end
      end
   end

   task automatic doReset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   localparam logic [DW-1:0] DA = 64'hAAAA_0000_0000_000A;
   localparam logic [DW-1:0] DB = 64'hBBBB_0000_0000_000B;
   localparam logic [DW-1:0] DC = 64'hCCCC_0000_0000_000C;
   localparam logic [DW-1:0] DD = 64'hDDDD_0000_0000_000D;
   localparam logic [DW-1:0] DE = 64'hEEEE_0000_0000_000E;
   localparam logic [DW-1:0] DF = 64'hFFFF_0000_0000_000F;

   logic [NU-1:0]    t4_stall [4];
   logic [NW*RW-1:0] t4_wrn   [4];

   initial begin
      t4_stall[0] = 5'b11100; t4_wrn[0] = {6'd2, 6'd1};
      t4_stall[1] = 5'b10011; t4_wrn[1] = {6'd4, 6'd3};
      t4_stall[2] = 5'b01110; t4_wrn[2] = {6'd1, 6'd5};
      t4_stall[3] = 5'b11001; t4_wrn[3] = {6'd3, 6'd2};

      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;

      // Idle after reset
      repeat (10) tick();
      checkOutput("t1_write_rn", 128'(write_rn), 128'(0));
      checkOutput("t1_stall", 128'(unit_stall), 128'(0));
      checkOutput("t1_cnt", 128'(conflict_cnt), 128'(0));

      // Three requesters, two ports: unit 2 waits one cycle
      applyStimulus(0, 1'b1, 6'd3, DA);
      applyStimulus(1, 1'b1, 6'd4, DB);
      applyStimulus(2, 1'b1, 6'd5, DC);
      #1 checkOutput("t2_stall", 128'(unit_stall), 128'(5'b00100));
      tick();
      checkOutput("t2_wrn0", 128'(write_rn), 128'({6'd4, 6'd3}));
      checkOutput("t2_wdata0", 128'(write_data), {DB, DA});
      applyStimulus(0, 1'b0, 6'd0, '0);
      applyStimulus(1, 1'b0, 6'd0, '0);
      #1 checkOutput("t2_stall_held", 128'(unit_stall), 128'(0));
      tick();
      checkOutput("t2_wrn1", 128'(write_rn), 128'({6'd0, 6'd5}));
      checkOutput("t2_wdata1", 128'(write_data), {64'd0, DC});
      clearUnits();

      // Duplicate rn: unit 3 deferred
      doReset();
      applyStimulus(1, 1'b1, 6'd7, DD);
      applyStimulus(3, 1'b1, 6'd7, DE);
      #1 checkOutput("t3_stall", 128'(unit_stall), 128'(5'b01000));
      tick();
      checkOutput("t3_wrn0", 128'(write_rn), 128'({6'd0, 6'd7}));
      checkOutput("t3_wdata0", 128'(write_data[DW-1:0]), 128'(DD));
      applyStimulus(1, 1'b0, 6'd0, '0);
      #1 checkOutput("t3_stall_held", 128'(unit_stall), 128'(0));
      tick();
      checkOutput("t3_wrn1", 128'(write_rn), 128'({6'd0, 6'd7}));
      checkOutput("t3_wdata1", 128'(write_data[DW-1:0]), 128'(DE));
      clearUnits();

      // All units requesting continuously
      doReset();
      for (int u = 0; u < NU; u++) applyStimulus(u, 1'b1, RW'(u + 1), 64'h100 + DW'(u));
      for (int c = 0; c < 4; c++) begin
         #1 checkOutput($sformatf("t4_stall_c%0d", c), 128'(unit_stall), 128'(t4_stall[c]));
         tick();
         checkOutput($sformatf("t4_wrn_c%0d", c), 128'(write_rn), 128'(t4_wrn[c]));
      end
      clearUnits();

      // Discard with rn 0 alongside a real write
      doReset();
      applyStimulus(2, 1'b1, 6'd0, DA);
      applyStimulus(4, 1'b1, 6'd9, DF);
      #1 checkOutput("t5_stall", 128'(unit_stall), 128'(0));
      tick();
      checkOutput("t5_wrn", 128'(write_rn), 128'({6'd0, 6'd9}));
      checkOutput("t5_wdata", 128'(write_data), {64'd0, DF});
      clearUnits();

      // Persistent conflict, then reset mid-stream
      doReset();
      applyStimulus(0, 1'b1, 6'd1, DA);
      applyStimulus(1, 1'b1, 6'd2, DB);
      applyStimulus(2, 1'b1, 6'd3, DC);
      #1 checkOutput("t6_stall", 128'(unit_stall), 128'(5'b00100));
      repeat (3) tick();
`ifdef COMMIT_ARB_STATS_EN
      checkOutput("t6_cnt_pre", 128'(conflict_cnt), 128'(3));
`else
      checkOutput("t6_cnt_pre", 128'(conflict_cnt), 128'(0));
`endif
      rst = 1'b1;
      tick();
      checkOutput("t6_wrn_rst", 128'(write_rn), 128'(0));
      checkOutput("t6_wdata_rst", 128'(write_data), 128'(0));
      checkOutput("t6_cnt_rst", 128'(conflict_cnt), 128'(0));
      rst = 1'b0;
      clearUnits();
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
